// File: rtl/fnn_pkg.sv
// Shared types and width helpers for the FNN layer sequencer.
package fnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    XFER,
    ARGMAX,
    DONE
  } fnn_state_e;

  // Index width that stays at least one bit wide for tiny counts.
  function automatic int unsigned class_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Last-layer score width: each layer grows the datapath by three bits.
  function automatic int unsigned score_w(input int unsigned in_w, input int unsigned n_layers);
    return in_w + 3 * n_layers;
  endfunction

endpackage

// File: rtl/fnn_argmax_serial.sv
// Streaming signed argmax over a fixed number of score beats; ties keep the lowest index.
module fnn_argmax_serial
  import fnn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_WIDTH = 28
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              clr,
  input  logic                              beat_valid,
  input  logic signed [SCORE_WIDTH-1:0]     beat_data,
  output logic [class_w(NUM_CLASSES)-1:0]   best_idx,
  output logic signed [SCORE_WIDTH-1:0]     best_score,
  output logic                              done_c
);

  localparam int unsigned CLASS_W = class_w(NUM_CLASSES);
  localparam logic [CLASS_W-1:0] LAST_BEAT = CLASS_W'(NUM_CLASSES - 1);

  logic [CLASS_W-1:0]            cnt_q, cnt_d;
  logic [CLASS_W-1:0]            idx_q, idx_d;
  logic signed [SCORE_WIDTH-1:0] best_q, best_d;

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    best_d = best_q;
    done_c = beat_valid && !clr && (cnt_q == LAST_BEAT);
    if (clr) begin
      cnt_d  = '0;
      idx_d  = '0;
      best_d = '0;
    end else if (beat_valid) begin
      // First beat always loads so stale scores never leak into a new pass.
      if ((cnt_q == '0) || (beat_data > best_q)) begin
        best_d = beat_data;
        idx_d  = cnt_q;
      end
      cnt_d = done_c ? '0 : cnt_q + CLASS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      best_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      best_q <= best_d;
    end
  end

  assign best_idx   = idx_q;
  assign best_score = best_q;

endmodule

// File: rtl/fnn_layer_sequencer.sv
// Controller chaining NUM_LAYERS FNN layers: weight load, pixel feed, layer transfers, argmax.
// Optional cycle counter output perf_cycles enabled by defining FNN_PERF_CNT_EN.
module fnn_layer_sequencer
  import fnn_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = 4,
  parameter int unsigned INDATA_WIDTH = 16,
  parameter int unsigned NO_INPUTS    = 784,
  parameter int unsigned NUM_CLASSES  = 10,
  parameter int unsigned SCORE_WIDTH  = score_w(INDATA_WIDTH, NUM_LAYERS),
  parameter int unsigned WBUS_WIDTH   = 23
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start_FNN,
  input  logic                            restart,
  input  logic                            load_weights,
  input  logic                            weight_valid,
  input  logic [WBUS_WIDTH-1:0]           weight_bus,
  output logic [WBUS_WIDTH-1:0]           weight_bus_out,
  output logic                            weight_valid_out,
  input  logic [NUM_LAYERS-1:0]           layer_ready,
  output logic [NUM_LAYERS-1:0]           layer_start,
  output logic [NUM_LAYERS-1:0]           layer_shift,
  input  logic [NUM_LAYERS-1:0]           layer_finished,
  input  logic [NUM_LAYERS-1:0]           layer_transferred,
  input  logic                            in_valid,
  input  logic [INDATA_WIDTH-1:0]         in_data,
  output logic                            in_ready,
  output logic [INDATA_WIDTH-1:0]         l1_data,
  output logic                            l1_valid,
  input  logic                            score_valid,
  input  logic [SCORE_WIDTH-1:0]          score_data,
  output logic [class_w(NUM_CLASSES)-1:0] max,
  output logic [SCORE_WIDTH-1:0]          max_score,
  output logic                            finish_FNN,
  output logic                            FNN_ready,
  output logic                            busy,
  output logic                            aborted
`ifdef FNN_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_cycles
`endif
);

  localparam int unsigned K_W     = class_w(NUM_LAYERS);
  localparam int unsigned PIX_W   = class_w(NO_INPUTS + 1);
  localparam int unsigned CLASS_W = class_w(NUM_CLASSES);
  localparam logic [K_W-1:0]        K_LAST  = K_W'(NUM_LAYERS - 1);
  localparam logic [PIX_W-1:0]      PIX_MAX = PIX_W'(NO_INPUTS);
  localparam logic [NUM_LAYERS-1:0] ONE_L   = NUM_LAYERS'(1);

  fnn_state_e               state_q, state_d;
  logic [K_W-1:0]           k_q, k_d, k_prev;
  logic [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic                     drained_q, drained_d;
  logic                     fin_seen_q, fin_seen_d;
  logic                     loaded_q, loaded_d;
  logic                     busy_q, busy_d;
  logic                     finish_q, finish_d;
  logic                     aborted_q, aborted_d;
  logic [CLASS_W-1:0]       max_q, max_d;
  logic [SCORE_WIDTH-1:0]   max_score_q, max_score_d;
  logic [NUM_LAYERS-1:0]    start_q, start_d;
  logic [NUM_LAYERS-1:0]    shift_q, shift_d;
  logic                     in_ready_q, in_ready_d;
  logic [INDATA_WIDTH-1:0]  l1_data_q, l1_data_d;
  logic                     l1_valid_q, l1_valid_d;
  logic [WBUS_WIDTH-1:0]    wbus_q, wbus_d;
  logic                     wvalid_q, wvalid_d;

  logic                     start_acc_c, abort_c, clr_c, beat_valid_c, argmax_done_c;
  logic                     drained_now, fin_now;
  logic [CLASS_W-1:0]       best_idx;
  logic [SCORE_WIDTH-1:0]   best_score;

  // Handshake-level events kept outside the main comb block to avoid false loops.
  assign start_acc_c  = (state_q == IDLE) && !load_weights && start_FNN && loaded_q;
  assign abort_c      = restart && (state_q inside {FEED, XFER, ARGMAX, DONE});
  assign clr_c        = start_acc_c || abort_c;
  assign beat_valid_c = (state_q == ARGMAX) && score_valid && !abort_c;

  fnn_argmax_serial #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_WIDTH (SCORE_WIDTH)
  ) u_argmax (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr_c),
    .beat_valid (beat_valid_c),
    .beat_data  (score_data),
    .best_idx   (best_idx),
    .best_score (best_score),
    .done_c     (argmax_done_c)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pix_cnt_d   = pix_cnt_q;
    drained_d   = drained_q;
    fin_seen_d  = fin_seen_q;
    loaded_d    = loaded_q;
    busy_d      = busy_q;
    finish_d    = finish_q;
    aborted_d   = 1'b0;
    max_d       = max_q;
    max_score_d = max_score_q;
    l1_data_d   = l1_data_q;
    l1_valid_d  = 1'b0;
    wbus_d      = wbus_q;
    wvalid_d    = 1'b0;
    start_d     = '0;
    shift_d     = '0;
    k_prev      = k_q - K_W'(1);
    drained_now = drained_q || layer_transferred[k_prev];
    fin_now     = fin_seen_q || layer_finished[k_q];

    unique case (state_q)
      IDLE: begin
        if (load_weights) begin
          state_d  = LOAD;
          loaded_d = 1'b0;
        end else if (start_acc_c) begin
          state_d     = FEED;
          busy_d      = 1'b1;
          finish_d    = 1'b0;
          max_d       = '0;
          max_score_d = '0;
          pix_cnt_d   = '0;
        end
      end
      LOAD: begin
        if (weight_valid) begin
          wbus_d   = weight_bus;
          wvalid_d = 1'b1;
        end
        if (!load_weights && (&layer_ready)) begin
          state_d  = IDLE;
          loaded_d = 1'b1;
        end
      end
      FEED: begin
        if (in_valid && in_ready_q) begin
          l1_data_d  = in_data;
          l1_valid_d = 1'b1;
          pix_cnt_d  = pix_cnt_q + PIX_W'(1);
        end
        if ((pix_cnt_q == PIX_MAX) && layer_finished[0]) begin
          state_d    = XFER;
          k_d        = K_W'(1);
          drained_d  = 1'b0;
          fin_seen_d = 1'b0;
        end
      end
      XFER: begin
        // Drain of layer k-1 and completion of layer k may arrive in either order.
        drained_d  = drained_now;
        fin_seen_d = fin_now;
        if (drained_now && fin_now) begin
          if (k_q == K_LAST) begin
            state_d = ARGMAX;
          end else begin
            k_d        = k_q + K_W'(1);
            drained_d  = 1'b0;
            fin_seen_d = 1'b0;
          end
        end
      end
      ARGMAX: begin
        if (argmax_done_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        max_d       = best_idx;
        max_score_d = best_score;
        finish_d    = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_c) begin
      state_d     = IDLE;
      aborted_d   = 1'b1;
      k_d         = '0;
      pix_cnt_d   = '0;
      drained_d   = 1'b0;
      fin_seen_d  = 1'b0;
      busy_d      = 1'b0;
      finish_d    = 1'b0;
      max_d       = '0;
      max_score_d = '0;
      l1_valid_d  = 1'b0;
    end

    // Layer control vectors follow the state being entered.
    unique case (state_d)
      FEED:    start_d = ONE_L;
      XFER: begin
        start_d = ONE_L << k_d;
        if (!drained_d) shift_d = ONE_L << (k_d - K_W'(1));
      end
      ARGMAX:  shift_d = ONE_L << K_LAST;
      default: ;
    endcase

    in_ready_d = (state_d == FEED) && (pix_cnt_d < PIX_MAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      pix_cnt_q   <= '0;
      drained_q   <= 1'b0;
      fin_seen_q  <= 1'b0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      aborted_q   <= 1'b0;
      max_q       <= '0;
      max_score_q <= '0;
      start_q     <= '0;
      shift_q     <= '0;
      in_ready_q  <= 1'b0;
      l1_data_q   <= '0;
      l1_valid_q  <= 1'b0;
      wbus_q      <= '0;
      wvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pix_cnt_q   <= pix_cnt_d;
      drained_q   <= drained_d;
      fin_seen_q  <= fin_seen_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      aborted_q   <= aborted_d;
      max_q       <= max_d;
      max_score_q <= max_score_d;
      start_q     <= start_d;
      shift_q     <= shift_d;
      in_ready_q  <= in_ready_d;
      l1_data_q   <= l1_data_d;
      l1_valid_q  <= l1_valid_d;
      wbus_q      <= wbus_d;
      wvalid_q    <= wvalid_d;
    end
  end

  assign weight_bus_out   = wbus_q;
  assign weight_valid_out = wvalid_q;
  assign layer_start      = start_q;
  assign layer_shift      = shift_q;
  assign in_ready         = in_ready_q;
  assign l1_data          = l1_data_q;
  assign l1_valid         = l1_valid_q;
  assign max              = max_q;
  assign max_score        = max_score_q;
  assign finish_FNN       = finish_q;
  assign FNN_ready        = loaded_q;
  assign busy             = busy_q;
  assign aborted          = aborted_q;

`ifdef FNN_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic [31:0] perf_cycles_q, perf_cycles_d;

  // Saturating run counter; the value captured at DONE includes the finish edge.
  always_comb begin
    perf_cnt_d    = perf_cnt_q;
    perf_cycles_d = perf_cycles_q;
    if (start_acc_c || abort_c) begin
      perf_cnt_d = '0;
    end else if (busy_q && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
    if (abort_c) begin
      perf_cycles_d = '0;
    end else if (state_q == DONE) begin
      perf_cycles_d = (perf_cnt_q == 32'hFFFF_FFFF) ? perf_cnt_q : perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cnt_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      perf_cnt_q    <= perf_cnt_d;
      perf_cycles_q <= perf_cycles_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
`endif

endmodule
